// File: rtl/e_mdu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: op codes,
// default latencies and the sequencing state type.
package mdu_pkg;

   localparam int MDU_OP_W    = 4;
   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8,
      MDU_MADD  = 4'd9,
      MDU_MADDU = 4'd10,
      MDU_MSUB  = 4'd11,
      MDU_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_e;

endpackage

// File: rtl/e_mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface e_mdu_if #(
   parameter int WIDTH = 32
);
   import mdu_pkg::*;

   logic                start;
   logic [MDU_OP_W-1:0] MDUOp;
   logic [WIDTH-1:0]    A;
   logic [WIDTH-1:0]    B;
   logic                busy;
   logic [WIDTH-1:0]    HI;
   logic [WIDTH-1:0]    LO;
   logic [WIDTH-1:0]    C;

   modport master (output start, MDUOp, A, B, input busy, HI, LO, C);
   modport slave  (input start, MDUOp, A, B, output busy, HI, LO, C);

endinterface

// File: rtl/e_mdu_div.sv
// Combinational signed/unsigned divider with the architectural results for
// divide-by-zero and the signed MIN / -1 overflow case.
module mdu_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   // SV signed / and % already truncate toward zero with remainder taking the
   // dividend's sign; only the two cases it leaves undefined need overriding.
   always_comb begin
      q = '0;
      r = '0;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (sgn && a == MIN_VAL && b == '1) begin
         q = MIN_VAL;
         r = '0;
      end else if (sgn) begin
         q = $unsigned($signed(a) / $signed(b));
         r = $unsigned($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
   end

endmodule

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_MADD_EN to enable
// the MADD/MADDU/MSUB/MSUBU accumulate ops; otherwise codes 9-12 act as NONE.
//
// state  | meaning
// S_IDLE | accepting issues; MTHI/MTLO write HI/LO directly
// S_RUN  | result held in hi_n/lo_n, counting down the op latency
module e_mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic     clk,
   input  logic     reset_n,
   e_mdu_if.slave   bus
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   mdu_state_e         state, state_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [WIDTH-1:0]   hi, lo, hi_nx, lo_nx;
   logic [WIDTH-1:0]   hi_n, lo_n, hi_n_nx, lo_n_nx;
   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0]   div_q, div_r;
   mdu_op_e            op;

   assign op = mdu_op_e'(bus.MDUOp);

   // Full-width products from pre-extended operands; the low 2*WIDTH bits of
   // the extended product are the exact signed/unsigned result.
   assign prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
   assign prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

   mdu_div_unit #(.WIDTH(WIDTH)) u_div (
      .sgn (op == MDU_DIV),
      .a   (bus.A),
      .b   (bus.B),
      .q   (div_q),
      .r   (div_r)
   );

`ifdef MDU_MADD_EN
   logic [2*WIDTH-1:0] acc;
   assign acc = {hi, lo};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         hi_n  <= '0;
         lo_n  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         hi    <= hi_nx;
         lo    <= lo_nx;
         hi_n  <= hi_n_nx;
         lo_n  <= lo_n_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hi_nx    = hi;
      lo_nx    = lo;
      hi_n_nx  = hi_n;
      lo_n_nx  = lo_n;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               case (op)
                  MDU_MULT: begin
                     {hi_n_nx, lo_n_nx} = prod_s;
                     cnt_nx   = CW'(MUL_LAT);
                     state_nx = S_RUN;
                  end
                  MDU_MULTU: begin
                     {hi_n_nx, lo_n_nx} = prod_u;
                     cnt_nx   = CW'(MUL_LAT);
                     state_nx = S_RUN;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     hi_n_nx  = div_r;
                     lo_n_nx  = div_q;
                     cnt_nx   = CW'(DIV_LAT);
                     state_nx = S_RUN;
                  end
                  MDU_MTHI: hi_nx = bus.A;
                  MDU_MTLO: lo_nx = bus.A;
`ifdef MDU_MADD_EN
                  MDU_MADD: begin
                     {hi_n_nx, lo_n_nx} = acc + prod_s;
                     cnt_nx   = CW'(MUL_LAT);
                     state_nx = S_RUN;
                  end
                  MDU_MADDU: begin
                     {hi_n_nx, lo_n_nx} = acc + prod_u;
                     cnt_nx   = CW'(MUL_LAT);
                     state_nx = S_RUN;
                  end
                  MDU_MSUB: begin
                     {hi_n_nx, lo_n_nx} = acc - prod_s;
                     cnt_nx   = CW'(MUL_LAT);
                     state_nx = S_RUN;
                  end
                  MDU_MSUBU: begin
                     {hi_n_nx, lo_n_nx} = acc - prod_u;
                     cnt_nx   = CW'(MUL_LAT);
                     state_nx = S_RUN;
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cnt == CW'(1)) begin
               hi_nx    = hi_n;
               lo_nx    = lo_n;
               cnt_nx   = '0;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.busy = (state == S_RUN);
   assign bus.HI   = hi;
   assign bus.LO   = lo;
   assign bus.C    = (op == MDU_MFHI) ? hi :
                     (op == MDU_MFLO) ? lo : '0;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed cases plus random ops checked against an
// arithmetic HI/LO model. Honours MDU_MADD_EN the same way as the design.
module tb_e_mdu;

   localparam int W       = 32;
   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;
   logic [W-1:0] exp_hi;
   logic [W-1:0] exp_lo;

   e_mdu_if #(.WIDTH(W)) bus ();

   e_mdu #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Architectural effect of an accepted op on HI/LO, and its busy latency.
   task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
      logic [63:0] p;
      logic [63:0] acc;
      int sa, sb;
      sa  = a;
      sb  = b;
      lat = 0;
      acc = {exp_hi, exp_lo};
      case (op)
         4'd1: begin p = longint'(sa) * longint'(sb); {exp_hi, exp_lo} = p; lat = MUL_LAT; end
         4'd2: begin p = {32'b0, a} * {32'b0, b};     {exp_hi, exp_lo} = p; lat = MUL_LAT; end
         4'd3, 4'd4: begin
            if (b == 0) begin
               exp_lo = '1; exp_hi = a;
            end else if (op == 4'd3 && sa == 32'sh8000_0000 && sb == -1) begin
               exp_lo = a;  exp_hi = '0;
            end else if (op == 4'd3) begin
               exp_lo = sa / sb; exp_hi = sa % sb;
            end else begin
               exp_lo = a / b;   exp_hi = a % b;
            end
            lat = DIV_LAT;
         end
         4'd7: exp_hi = a;
         4'd8: exp_lo = a;
`ifdef MDU_MADD_EN
         4'd9:  begin p = longint'(sa) * longint'(sb); {exp_hi, exp_lo} = acc + p; lat = MUL_LAT; end
         4'd10: begin p = {32'b0, a} * {32'b0, b};     {exp_hi, exp_lo} = acc + p; lat = MUL_LAT; end
         4'd11: begin p = longint'(sa) * longint'(sb); {exp_hi, exp_lo} = acc - p; lat = MUL_LAT; end
         4'd12: begin p = {32'b0, a} * {32'b0, b};     {exp_hi, exp_lo} = acc - p; lat = MUL_LAT; end
`endif
         default: ;
      endcase
   endtask

   // Issue one op, scramble operands afterwards, measure busy and check HI/LO.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
      int lat, cnt;
      model(op, a, b, lat);
      @(negedge clk);
      bus.start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
      @(negedge clk);
      bus.start = 1'b0; bus.MDUOp = 4'd0; bus.A = $urandom; bus.B = $urandom;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt <= 64) begin
         cnt++;
         @(negedge clk);
      end
      chk({tag, ".busy_cycles"}, 64'(cnt), 64'(lat));
      chk({tag, ".hi"}, 64'(bus.HI), 64'(exp_hi));
      chk({tag, ".lo"}, 64'(bus.LO), 64'(exp_lo));
   endtask

   task automatic check_c(input string tag);
      logic [3:0] other;
      bus.MDUOp = 4'd5; #1;
      chk({tag, ".c_mfhi"}, 64'(bus.C), 64'(exp_hi));
      bus.MDUOp = 4'd6; #1;
      chk({tag, ".c_mflo"}, 64'(bus.C), 64'(exp_lo));
      other = 4'($urandom_range(0, 15));
      if (other == 4'd5 || other == 4'd6) other = 4'd13;
      bus.MDUOp = other; #1;
      chk({tag, ".c_other"}, 64'(bus.C), 64'd0);
      bus.MDUOp = 4'd0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         3: return '0;
         4: return '1;
         5: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      n_cmp = 0; n_err = 0;
      exp_hi = '0; exp_lo = '0;
      reset_n = 1'b0;
      bus.start = 1'b0; bus.MDUOp = 4'd0; bus.A = '0; bus.B = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("reset.busy", 64'(bus.busy), 64'd0);
      chk("reset.hi", 64'(bus.HI), 64'd0);
      chk("reset.lo", 64'(bus.LO), 64'd0);
      chk("reset.c", 64'(bus.C), 64'd0);

      do_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
      chk("mult.hi_lit", 64'(bus.HI), 64'hFFFF_FFFF);
      chk("mult.lo_lit", 64'(bus.LO), 64'hFFFF_FFFA);
      do_op(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
      chk("multu.hi_lit", 64'(bus.HI), 64'h0000_0002);
      chk("multu.lo_lit", 64'(bus.LO), 64'hFFFF_FFFA);
      do_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div");
      chk("div.lo_lit", 64'(bus.LO), 64'hFFFF_FFFD);
      chk("div.hi_lit", 64'(bus.HI), 64'hFFFF_FFFF);
      do_op(4'd4, 32'd7, 32'd0, "divu0");
      chk("divu0.lo_lit", 64'(bus.LO), 64'hFFFF_FFFF);
      chk("divu0.hi_lit", 64'(bus.HI), 64'd7);
      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
      chk("divovf.lo_lit", 64'(bus.LO), 64'h8000_0000);

      do_op(4'd7, 32'h1234, 32'd0, "mthi");
      check_c("mthi");
      chk("mthi.c_lit", 64'(bus.HI), 64'h1234);

      // Issue during busy, held through the edge where busy falls: both dropped.
      model(4'd1, 32'd1000, 32'd77, lat);
      @(negedge clk);
      bus.start = 1'b1; bus.MDUOp = 4'd1; bus.A = 32'd1000; bus.B = 32'd77;
      @(negedge clk);
      bus.MDUOp = 4'd8; bus.A = 32'd5;
      repeat (lat - 1) @(negedge clk);
      chk("drop.busy_before_fall", 64'(bus.busy), 64'd1);
      @(negedge clk);
      bus.start = 1'b0; bus.MDUOp = 4'd0;
      chk("drop.busy_after", 64'(bus.busy), 64'd0);
      chk("drop.lo", 64'(bus.LO), 64'(exp_lo));
      chk("drop.hi", 64'(bus.HI), 64'(exp_hi));
      @(negedge clk);
      chk("drop.lo_later", 64'(bus.LO), 64'(exp_lo));

      // Reset in the middle of a divide discards it.
      @(negedge clk);
      bus.start = 1'b1; bus.MDUOp = 4'd3; bus.A = 32'd100; bus.B = 32'd7;
      @(negedge clk);
      bus.start = 1'b0; bus.MDUOp = 4'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      exp_hi = '0; exp_lo = '0;
      chk("rstmid.busy", 64'(bus.busy), 64'd0);
      chk("rstmid.hi", 64'(bus.HI), 64'd0);
      chk("rstmid.lo", 64'(bus.LO), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("rstmid.busy_later", 64'(bus.busy), 64'd0);
      chk("rstmid.hi_later", 64'(bus.HI), 64'd0);
      chk("rstmid.lo_later", 64'(bus.LO), 64'd0);

`ifdef MDU_MADD_EN
      do_op(4'd7, 32'd0, 32'd0, "acc_hi0");
      do_op(4'd8, 32'd10, 32'd0, "acc_lo10");
      do_op(4'd9, 32'd3, 32'd4, "madd");
      chk("madd.lo_lit", 64'(bus.LO), 64'd22);
      do_op(4'd12, 32'd1, 32'd23, "msubu");
      chk("msubu.hilo_lit", {32'(bus.HI), 32'(bus.LO)}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      do_op(4'd8, 32'd10, 32'd0, "pre_madd");
      do_op(4'd9, 32'd3, 32'd4, "madd_off");
      chk("madd_off.lo_lit", 64'(bus.LO), 64'd10);
`endif

      for (int i = 0; i < 40; i++) begin
         do_op(4'($urandom_range(0, 15)), pick(), pick(), $sformatf("rand%0d", i));
         check_c($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
